// File: rtl/egress_rr_arbiter.sv
// Round-robin egress arbiter: grants one ready port FIFO at a time and pops up to
// MAX_BURST words into a single registered output slot with valid/ready handshake.
module egress_rr_arbiter #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arb_en,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_data,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORD_WIDTH-1:0]              out_data,
  output logic [2:0]                         out_port,
  output logic                               busy
);

  localparam int IDXW = (NUM_OF_PORTS > 2) ? $clog2(NUM_OF_PORTS) : 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         gnt_q, gnt_d;
  logic [IDXW-1:0]         last_q, last_d;
  logic [3:0]              bcnt_q, bcnt_d, bcntInc;
  logic                    out_valid_q;
  logic [WORD_WIDTH-1:0]   out_data_q;
  logic [2:0]              out_port_q;

  logic [WORD_WIDTH-1:0]   portWord [NUM_OF_PORTS];
  logic [IDXW-1:0]         pick, cand;
  logic                    pickValid;
  logic                    slotFree, grantReady, pop;

  always_comb begin
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      portWord[i] = port_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Scan downward from the farthest candidate so the nearest ready port after last wins.
  always_comb begin
    pick      = last_q;
    pickValid = 1'b0;
    cand      = '0;
    for (int k = NUM_OF_PORTS; k >= 1; k--) begin
      cand = IDXW'((int'(last_q) + k) % NUM_OF_PORTS);
      if (port_ready[cand]) begin
        pick      = cand;
        pickValid = 1'b1;
      end
    end
  end

  assign grantReady = port_ready[gnt_q];
  assign slotFree   = !out_valid_q || out_ready;
  assign bcntInc    = bcnt_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      bcnt_q  <= '0;
      last_q  <= IDXW'(NUM_OF_PORTS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (arb_en && pickValid) begin
          state_d = XFER;
          gnt_d   = pick;
          bcnt_d  = '0;
        end
      end
      XFER: begin
        if (!grantReady) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end else if (slotFree) begin
          bcnt_d = bcntInc;
          if (bcntInc == 4'(MAX_BURST)) begin
            state_d = IDLE;
            last_d  = gnt_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    pop       = (state_q == XFER) && grantReady && slotFree;
    port_read = '0;
    if (pop) begin
      port_read[gnt_q] = 1'b1;
    end
    busy = (state_q == XFER);
  end

  // A pop refills the slot in the same edge that the old word is accepted, so no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= portWord[gnt_q];
      out_port_q  <= 3'(gnt_q);
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// Bench for egress_rr_arbiter: per-port FIFO queues feed the DUT, and a transaction-level
// round-robin model predicts the egress word stream, plus directed cycle-exact scenarios.
module tb_egress_rr_arbiter;

  localparam int N  = 4;
  localparam int WW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic            out_ready;
  logic [N-1:0]    port_ready;
  logic [N*WW-1:0] port_data;
  logic [N-1:0]    port_read;
  logic            out_valid;
  logic [WW-1:0]   out_data;
  logic [2:0]      out_port;
  logic            busy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [WW-1:0] fifo [N][$];
  int            expPort [$];
  logic [WW-1:0] expData [$];
  int            lastModel;
  bit            sbOn;
  bit            prevStall;
  logic [WW-1:0] prevData;
  logic [2:0]    prevPort;

  bit expRd    [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  bit expV     [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  bit expBusy  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int expDat   [10] = '{0, 0, 'hA0, 'hA1, 'hA2, 'hA3, 0, 'hA4, 'hA5, 0};

  always #5 clk = ~clk;

  egress_rr_arbiter #(
    .NUM_OF_PORTS(N),
    .WORD_WIDTH  (WW),
    .MAX_BURST   (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .port_ready(port_ready),
    .port_data (port_data),
    .port_read (port_read),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_port  (out_port),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      port_ready[i]        = (fifo[i].size() != 0);
      port_data[i*WW +: WW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic en);
    out_ready = rdy;
    arb_en    = en;
    driveInputs();
  endtask

  task automatic checkOutput();
    check("rd_onehot", 32'($countones(port_read) <= 1), 32'd1);
    if (port_read != '0) begin
      check("rd_slot_free", 32'(!out_valid || out_ready), 32'd1);
      check("rd_port_ready", 32'(port_read & ~port_ready), 32'd0);
      check("rd_busy", 32'(busy), 32'd1);
    end
    if (prevStall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prevData));
      check("hold_port", 32'(out_port), 32'(prevPort));
    end
    if (sbOn && out_valid && out_ready) begin
      check("sb_pending", 32'(expPort.size() != 0), 32'd1);
      if (expPort.size() != 0) begin
        check("sb_port", 32'(out_port), 32'(expPort.pop_front()));
        check("sb_data", 32'(out_data), 32'(expData.pop_front()));
      end
    end
    prevStall = out_valid && !out_ready;
    prevData  = out_data;
    prevPort  = out_port;
  endtask

  // Sampled pop strobes are applied to the queues just after the edge (FWFT head update).
  task automatic advance();
    logic [N-1:0] pr;
    pr = port_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pr[i]) void'(fifo[i].pop_front());
    end
  endtask

  task automatic predict();
    int len [N];
    int pos [N];
    int total, p, n;
    bit found;
    total = 0;
    for (int i = 0; i < N; i++) begin
      len[i] = fifo[i].size();
      pos[i] = 0;
      total += len[i];
    end
    while (total > 0) begin
      found = 0;
      p     = lastModel;
      for (int k = 1; k <= N; k++) begin
        if (!found && len[(lastModel + k) % N] != 0) begin
          found = 1;
          p     = (lastModel + k) % N;
        end
      end
      n = (len[p] < MB) ? len[p] : MB;
      for (int j = 0; j < n; j++) begin
        expPort.push_back(p);
        expData.push_back(fifo[p][pos[p] + j]);
      end
      pos[p]   += n;
      len[p]   -= n;
      total    -= n;
      lastModel = p;
    end
  endtask

  // mode 0: always ready, 1: random backpressure, 2: 3-cycle stall after first word
  task automatic runScenario(input string tag, input int mode);
    int   cyc, stallLeft;
    bit   seenValid;
    logic rdy;
    predict();
    sbOn      = 1;
    cyc       = 0;
    stallLeft = 3;
    seenValid = 0;
    while ((expPort.size() != 0 || out_valid || busy) && cyc < 400) begin
      if (out_valid) seenValid = 1;
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && seenValid && stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end else rdy = 1'b1;
      applyStimulus(rdy, 1'b1);
      @(negedge clk);
      checkOutput();
      if (mode == 2 && !rdy) check({tag, "_stall_noread"}, 32'(port_read), 32'd0);
      advance();
      cyc++;
    end
    check({tag, "_drained"}, 32'(expPort.size()), 32'd0);
    if (mode == 2) check({tag, "_stalled"}, 32'(stallLeft), 32'd0);
    sbOn = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  pops, x;
    bit  found;
    rst        = 1'b1;
    arb_en     = 1'b0;
    out_ready  = 1'b0;
    port_ready = '0;
    port_data  = '0;
    sbOn       = 0;
    prevStall  = 0;
    prevData   = '0;
    prevPort   = '0;
    lastModel  = N - 1;

    // Reset holds everything quiet even with ports ready and arbitration enabled
    for (int i = 0; i < N; i++) fifo[i].push_back(WW'(8'h10 + i));
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    check("rst_port_read", 32'(port_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_port", 32'(out_port), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runScenario("rr_order", 0);

    // Single port with six words: exact cycle pattern including latency and regrant
    for (int i = 0; i < 6; i++) fifo[0].push_back(WW'(8'hA0 + i));
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput();
      check($sformatf("burst_c%0d_rd", k), 32'(port_read), expRd[k] ? 32'd1 : 32'd0);
      check($sformatf("burst_c%0d_valid", k), 32'(out_valid), 32'(expV[k]));
      check($sformatf("burst_c%0d_busy", k), 32'(busy), 32'(expBusy[k]));
      if (expV[k]) begin
        check($sformatf("burst_c%0d_data", k), 32'(out_data), 32'(expDat[k]));
        check($sformatf("burst_c%0d_port", k), 32'(out_port), 32'd0);
      end
      advance();
    end
    lastModel = 0;

    for (int i = 0; i < 5; i++) fifo[2].push_back(WW'($urandom));
    runScenario("stall", 2);

    for (int i = 0; i < 2; i++) fifo[1].push_back(WW'($urandom));
    for (int i = 0; i < 2; i++) fifo[2].push_back(WW'($urandom));
    runScenario("empty_exit", 0);

    // Arbitration disabled: nothing granted although ports are ready
    for (int i = 0; i < 2; i++) fifo[0].push_back(WW'($urandom));
    for (int i = 0; i < 2; i++) fifo[3].push_back(WW'($urandom));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput();
      check($sformatf("en_off_c%0d_busy", k), 32'(busy), 32'd0);
      check($sformatf("en_off_c%0d_rd", k), 32'(port_read), 32'd0);
      advance();
    end
    runScenario("en_release", 0);

    // Dropping arb_en right after the grant still completes the full burst
    x = (lastModel + 1) % N;
    for (int i = 0; i < 6; i++) fifo[x].push_back(WW'($urandom));
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, k == 0);
      @(negedge clk);
      checkOutput();
      if (port_read != '0) pops++;
      advance();
    end
    check("en_drop_pops", 32'(pops), 32'(MB));
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_left", 32'(fifo[x].size()), 32'd2);
    lastModel = x;
    runScenario("en_rest", 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 7);
        for (int j = 0; j < n; j++) fifo[i].push_back(WW'($urandom));
      end
      runScenario($sformatf("rand%0d", r), 1);
    end

    // Reset in the middle of a burst discards the pending word and restarts at port 0
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 6; j++) fifo[i].push_back(WW'($urandom));
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput();
      if (port_read != '0) found = 1;
      advance();
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    check("rst_mid_valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_rd", 32'(port_read), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    prevStall = 0;
    lastModel = N - 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    runScenario("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
